// File: rtl/segway_math.sv
// Soft-start scaling, steer mixing, deadzone shaping and saturation to 12-bit wheel speeds.
// One register stage (latency 1 clk); no handshake, so a new input is accepted every cycle.
module segway_math #(
  parameter logic [12:0]        MIN_DUTY        = 13'h0A8,
  parameter logic [7:0]         LOW_TORQUE_BAND = 8'h2A,
  parameter logic [3:0]         GAIN_MULT       = 4'h4,
  parameter logic [11:0]        STEER_MIN       = 12'h200,
  parameter logic [11:0]        STEER_MAX       = 12'hE00,
  parameter logic [11:0]        STEER_CTR       = 12'h7FF,
  parameter logic signed [11:0] TOO_FAST_THR    = 12'sd1536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] PID_cntrl,
  input  logic [7:0]         ss_tmr,
  input  logic [11:0]        steer_pot,
  input  logic               en_steer,
  input  logic               pwr_up,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               too_fast
);

  logic signed [20:0] pid_prod;
  logic signed [12:0] pid_ss;
  logic [11:0]        steer_lim;
  logic signed [11:0] steer_s;
  logic signed [13:0] steer_x3;
  logic signed [12:0] steer_scl;
  logic signed [12:0] lft_t, rght_t;
  logic signed [11:0] lft_nxt, rght_nxt;
  logic               fast_nxt;

  // Bits [19:8] of the product equal an arithmetic shift right by 8.
  assign pid_prod = PID_cntrl * $signed({1'b0, ss_tmr});
  assign pid_ss   = {pid_prod[19], pid_prod[19:8]};

  assign steer_lim = (steer_pot < STEER_MIN) ? STEER_MIN :
                     (steer_pot > STEER_MAX) ? STEER_MAX : steer_pot;
  assign steer_s   = $signed(steer_lim - STEER_CTR);
  assign steer_x3  = (14'(steer_s) <<< 1) + 14'(steer_s);
  assign steer_scl = 13'(steer_x3 >>> 4);

  assign lft_t  = en_steer ? pid_ss + steer_scl : pid_ss;
  assign rght_t = en_steer ? pid_ss - steer_scl : pid_ss;

  function automatic logic signed [11:0] shape_sat(input logic signed [12:0] t,
                                                   input logic pwr);
    logic signed [12:0] band;
    logic signed [12:0] shaped;
    band   = $signed({5'd0, LOW_TORQUE_BAND});
    shaped = 13'sd0;
    if (!pwr)
      shaped = 13'sd0;
    else if (t > band)
      shaped = t + $signed(MIN_DUTY);
    else if (t < -band)
      shaped = t - $signed(MIN_DUTY);
    else
      shaped = 13'(t * $signed({9'd0, GAIN_MULT}));
    if (shaped > 13'sd2047)
      return 12'sd2047;
    else if (shaped < -13'sd2048)
      return -12'sd2048;
    else
      return shaped[11:0];
  endfunction

  assign lft_nxt  = shape_sat(lft_t, pwr_up);
  assign rght_nxt = shape_sat(rght_t, pwr_up);
  assign fast_nxt = (lft_nxt > TOO_FAST_THR) || (rght_nxt > TOO_FAST_THR);

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      too_fast <= 1'b0;
    end else begin
      lft_spd  <= lft_nxt;
      rght_spd <= rght_nxt;
      too_fast <= fast_nxt;
    end
  end

endmodule

// File: tb/tb_segway_math.sv
// Directed vectors for segway_math plus power-down, reset and latency sequences.
module tb_segway_math;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] PID_cntrl;
  logic [7:0]         ss_tmr;
  logic [11:0]        steer_pot;
  logic               en_steer;
  logic               pwr_up;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               too_fast;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  segway_math dut (
    .clk       (clk),
    .rst       (rst),
    .PID_cntrl (PID_cntrl),
    .ss_tmr    (ss_tmr),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .pwr_up    (pwr_up),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .too_fast  (too_fast)
  );

  typedef struct {
    logic [11:0] pid;
    logic [7:0]  ss;
    logic [11:0] pot;
    logic        en;
    logic        pwr;
    int          exp_l;
    int          exp_r;
    logic        exp_f;
  } vec_t;

  vec_t vecs[19];

  task automatic check_out(input string name, input int exp_l, input int exp_r,
                           input logic exp_f);
    checks++;
    if (int'(lft_spd) != exp_l || int'(rght_spd) != exp_r || too_fast !== exp_f) begin
      errors++;
      $display("FAIL %s: got lft=%0d rght=%0d fast=%b, expected lft=%0d rght=%0d fast=%b",
               name, lft_spd, rght_spd, too_fast, exp_l, exp_r, exp_f);
    end
  endtask

  task automatic drive(input logic [11:0] pid, input logic [7:0] ss, input logic [11:0] pot,
                       input logic en, input logic pwr);
    PID_cntrl = pid;
    ss_tmr    = ss;
    steer_pot = pot;
    en_steer  = en;
    pwr_up    = pwr;
  endtask

  initial begin
    //            pid      ss     pot      en    pwr   lft    rght   fast
    vecs[0]  = '{12'h3FF, 8'hFF, 12'h7FF, 1'b1, 1'b1,  1187,  1187, 1'b0};
    vecs[1]  = '{12'h3FF, 8'hFF, 12'h000, 1'b1, 1'b1,   899,  1475, 1'b0};
    vecs[2]  = '{12'h3FF, 8'hFF, 12'hFFF, 1'b1, 1'b1,  1475,   899, 1'b0};
    vecs[3]  = '{12'h010, 8'hFF, 12'h7FF, 1'b0, 1'b1,    60,    60, 1'b0};
    vecs[4]  = '{12'hC00, 8'h80, 12'h7FF, 1'b0, 1'b1,  -680,  -680, 1'b0};
    vecs[5]  = '{12'h7FF, 8'hFF, 12'h7FF, 1'b0, 1'b1,  2047,  2047, 1'b1};
    vecs[6]  = '{12'h02B, 8'hFF, 12'h7FF, 1'b0, 1'b1,   168,   168, 1'b0};
    vecs[7]  = '{12'h02C, 8'hFF, 12'h7FF, 1'b0, 1'b1,   211,   211, 1'b0};
    vecs[8]  = '{12'hFD6, 8'hFF, 12'h7FF, 1'b0, 1'b1,  -168,  -168, 1'b0};
    vecs[9]  = '{12'hFD5, 8'hFF, 12'h7FF, 1'b0, 1'b1,  -211,  -211, 1'b0};
    vecs[10] = '{12'h800, 8'hFF, 12'h7FF, 1'b0, 1'b1, -2048, -2048, 1'b0};
    vecs[11] = '{12'h55E, 8'hFF, 12'h7FF, 1'b0, 1'b1,  1536,  1536, 1'b0};
    vecs[12] = '{12'h55F, 8'hFF, 12'h7FF, 1'b0, 1'b1,  1537,  1537, 1'b1};
    vecs[13] = '{12'h3FF, 8'hFF, 12'h000, 1'b0, 1'b1,  1187,  1187, 1'b0};
    vecs[14] = '{12'h3FF, 8'hFF, 12'h900, 1'b1, 1'b1,  1235,  1139, 1'b0};
    vecs[15] = '{12'h000, 8'h00, 12'h7F0, 1'b1, 1'b1,   -12,    12, 1'b0};
    vecs[16] = '{12'h7FF, 8'hFF, 12'h7FF, 1'b0, 1'b0,     0,     0, 1'b0};
    vecs[17] = '{12'h3FF, 8'h00, 12'h7FF, 1'b0, 1'b1,     0,     0, 1'b0};
    vecs[18] = '{12'h55E, 8'hFF, 12'hFFF, 1'b1, 1'b1,  1824,  1248, 1'b1};

    rst = 1'b1;
    drive(12'h7FF, 8'hFF, 12'h7FF, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 0, 0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].pid, vecs[i].ss, vecs[i].pot, vecs[i].en, vecs[i].pwr);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_f);
    end

    // Saturate, then power down, then reset with live inputs.
    drive(12'h7FF, 8'hFF, 12'h7FF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_out("seq_saturate", 2047, 2047, 1'b1);
    pwr_up = 1'b0;
    @(posedge clk);
    #1;
    check_out("seq_pwr_down", 0, 0, 1'b0);
    pwr_up = 1'b1;
    @(posedge clk);
    #1;
    check_out("seq_pwr_back", 2047, 2047, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_out("seq_reset_override", 0, 0, 1'b0);
    rst = 1'b0;

    // Outputs hold until the next edge after an input change.
    drive(12'hC00, 8'h80, 12'h7FF, 1'b0, 1'b1);
    @(negedge clk);
    check_out("seq_latency_hold", 0, 0, 1'b0);
    @(posedge clk);
    #1;
    check_out("seq_latency_update", -680, -680, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
